// File: rtl/pipe_addsub.sv
// pipe_addsub: pipelined WIDTH-bit add/subtract unit, one CW-bit chunk per
// stage, with a valid/ready handshake on the input and output sides.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   input handshake (in_ready = pipeline may advance)
//   a, b, c_in, sub       operands, carry/borrow in, 0=add 1=subtract
//   out_valid / out_ready output handshake
//   sum, c_out, ovf       result, raw carry out of MSB, signed overflow
module pipe_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int CW = WIDTH / STAGES;

    // The whole pipe moves as one shift register; a stalled output
    // freezes every stage, bubbles included.
    logic adv;

    // Inter-stage links: element k feeds stage k, element k+1 is the
    // register written by stage k. Element 0 is the conditioned input.
    logic             v_w  [STAGES+1];
    logic [WIDTH-1:0] s_w  [STAGES+1];
    logic             cy_w [STAGES+1];
    logic [WIDTH-1:0] a_w  [STAGES];
    logic [WIDTH-1:0] b_w  [STAGES];
    logic             cm_w;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Subtraction is a + ~b + ~c_in; the mode is folded in here and
    // never travels down the pipe.
    assign v_w[0]  = in_valid;
    assign s_w[0]  = '0;
    assign cy_w[0] = c_in ^ sub;
    assign a_w[0]  = a;
    assign b_w[0]  = sub ? ~b : b;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        logic [CW-1:0]    ac;
        logic [CW-1:0]    bc;
        logic [CW:0]      r;
        logic [WIDTH-1:0] s_d;
        logic             v_q;
        logic [WIDTH-1:0] s_q;
        logic             c_q;

        assign ac = a_w[k][k*CW +: CW];
        assign bc = b_w[k][k*CW +: CW];
        assign r  = {1'b0, ac} + {1'b0, bc} + {{CW{1'b0}}, cy_w[k]};

        // Low chunks already resolved pass through; this stage fills
        // in its own chunk.
        always_comb begin
            s_d = s_w[k];
            s_d[k*CW +: CW] = r[CW-1:0];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= 1'b0;
                s_q <= '0;
                c_q <= 1'b0;
            end else if (adv) begin
                v_q <= v_w[k];
                s_q <= s_d;
                c_q <= r[CW];
            end
        end

        assign v_w[k+1]  = v_q;
        assign s_w[k+1]  = s_q;
        assign cy_w[k+1] = c_q;

        if (k < STAGES - 1) begin : g_fwd
            // Only chunks above this one are still needed downstream.
            localparam logic [WIDTH-1:0] KEEP =
                {WIDTH{1'b1}} << ((k + 1) * CW);

            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_w[k] & KEEP;
                    b_q <= b_w[k] & KEEP;
                end
            end

            assign a_w[k+1] = a_q;
            assign b_w[k+1] = b_q;
        end else begin : g_last
            // Carry into the MSB, recovered from the MSB sum bit:
            // s = a ^ b ^ cin  =>  cin = s ^ a ^ b.
            logic m_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    m_q <= 1'b0;
                end else if (adv) begin
                    m_q <= r[CW-1] ^ ac[CW-1] ^ bc[CW-1];
                end
            end

            assign cm_w = m_q;
        end
    end

    assign out_valid = v_w[STAGES];
    assign sum       = s_w[STAGES];
    assign c_out     = cy_w[STAGES];
    assign ovf       = cm_w ^ cy_w[STAGES];

endmodule
